// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU control path.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } seq_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/wait_timer.sv
// Consecutive not-ready cycle counter shared by the FETCH and MEM waits.
module wait_timer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  // A zero TIMEOUT disables expiry; keep at least one counter bit so the code stays legal.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count_q;

  // Count not-ready cycles; hold at the limit, clear on leaving or completing a wait.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (count_en && (count_q != CNT_W'(TIMEOUT))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with memory timeout.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_halt,
  input  logic               writes_reg,
  output logic               imem_req,
  output logic               ir_load,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               reg_write,
  output logic               pc_enable,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] retired
);

  seq_state_t state_q;
  seq_state_t state_d;
  logic       in_wait;
  logic       wait_ready;
  logic       expired;
  logic       retire_c;

  assign in_wait    = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;

  // Single timer serves both waits; it restarts whenever a wait ends or is not active.
  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!in_wait || wait_ready),
    .count_en (in_wait && !wait_ready),
    .expired  (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; reset masks every strobe so a discarded instruction never retires.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    retire_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (writes_reg) begin
          state_d = S_WB;
        end else begin
          retire_c = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store && !is_load;
        if (dmem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            retire_c = 1'b1;
          end
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire_c  = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (retire_c) begin
      state_d = run ? S_FETCH : S_IDLE;
    end

    if (rst) begin
      imem_req  = 1'b0;
      ir_load   = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      halted    = 1'b0;
      fault     = 1'b0;
      retire_c  = 1'b0;
    end

    pc_enable = retire_c;
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (retire_c && (retired != '1)) begin
      retired <= retired + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_ready;
  logic        dmem_ready;
  logic        is_load;
  logic        is_store;
  logic        is_halt;
  logic        writes_reg;
  logic        imem_req;
  logic        ir_load;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_write;
  logic        pc_enable;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  cpu_sequencer #(
    .TIMEOUT (15),
    .COUNT_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_halt    (is_halt),
    .writes_reg (writes_reg),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .reg_write  (reg_write),
    .pc_enable  (pc_enable),
    .halted     (halted),
    .fault      (fault),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Count pc_enable pulses as the PC logic would see them at the edge.
  always @(posedge clk) begin
    if (pc_enable) pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs may then be changed and outputs checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] strobes();
    return {imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_enable, halted, fault};
  endfunction

  initial begin
    int dreq_cnt;
    int pc_cyc;
    int snap;
    int last;
    int bad_gap;

    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0; writes_reg = 1'b0;
    do_reset();
    settle();
    chk("reset_strobes", 64'(strobes()), 64'h0);
    chk("reset_retired", 64'(retired), 64'd0);

    // ALU op with writeback, readies high: retire on cycle 4.
    writes_reg = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; run = 1'b1;
    tick();                                   // cycle 1: FETCH
    chk("alu_c1_ir_load", 64'(ir_load), 64'd1);
    tick();                                   // cycle 2: DECODE
    chk("alu_c2_pc", 64'(pc_enable), 64'd0);
    tick();                                   // cycle 3: EXEC
    chk("alu_c3_pc", 64'(pc_enable), 64'd0);
    tick();                                   // cycle 4: WB
    run = 1'b0;
    settle();
    chk("alu_c4_pc", 64'(pc_enable), 64'd1);
    chk("alu_c4_regw", 64'(reg_write), 64'd1);
    tick();
    chk("alu_retired", 64'(retired), 64'd1);
    chk("alu_idle_strobes", 64'(strobes()), 64'h0);

    // Load with three data wait states; run dropped while in MEM.
    is_load = 1'b1; dmem_ready = 1'b0; run = 1'b1;
    dreq_cnt = 0; pc_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      dmem_ready = (c == 7);
      if (c == 5) run = 1'b0;
      settle();
      if (dmem_req) dreq_cnt++;
      if (pc_enable && pc_cyc == 0) pc_cyc = c;
      if (c == 8) chk("load_wb_regw", 64'(reg_write), 64'd1);
    end
    chk("load_dreq_cycles", 64'(dreq_cnt), 64'd4);
    chk("load_pc_cycle", 64'(pc_cyc), 64'd8);
    tick();
    chk("load_park_strobes", 64'(strobes()), 64'h0);
    chk("load_retired", 64'(retired), 64'd2);

    // Store: retires in MEM with a write strobe and no register write.
    is_load = 1'b0; is_store = 1'b1; writes_reg = 1'b0; dmem_ready = 1'b1; run = 1'b1;
    tick(); tick(); tick();
    chk("store_c3_pc", 64'(pc_enable), 64'd0);
    tick();                                   // cycle 4: MEM
    run = 1'b0;
    settle();
    chk("store_dreq", 64'(dmem_req), 64'd1);
    chk("store_we", 64'(dmem_we), 64'd1);
    chk("store_regw", 64'(reg_write), 64'd0);
    chk("store_pc", 64'(pc_enable), 64'd1);
    tick();
    chk("store_retired", 64'(retired), 64'd3);

    // Ten back-to-back branches from a fresh reset.
    do_reset();
    is_store = 1'b0; run = 1'b1;
    snap = pulses; last = 0; bad_gap = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 30) run = 1'b0;
      settle();
      if (pc_enable) begin
        if (c - last != 3) bad_gap++;
        last = c;
      end
    end
    tick();
    chk("br_pulses", 64'(pulses - snap), 64'd10);
    chk("br_gaps", 64'(bad_gap), 64'd0);
    chk("br_retired", 64'(retired), 64'd10);
    chk("br_idle_strobes", 64'(strobes()), 64'h0);

    // Halt at decode: sticky, ignores run.
    is_halt = 1'b1; run = 1'b1;
    snap = pulses;
    tick(); tick();                           // DECODE
    chk("halt_decode_h", 64'(halted), 64'd0);
    tick();
    chk("halt_set", 64'(halted), 64'd1);
    run = 1'b0; tick(); run = 1'b1; tick(); tick();
    chk("halt_held", 64'(halted), 64'd1);
    chk("halt_no_fetch", 64'(imem_req), 64'd0);
    chk("halt_no_pc", 64'(pulses - snap), 64'd0);
    chk("halt_retired", 64'(retired), 64'd10);
    do_reset();
    settle();
    chk("halt_cleared", 64'(halted), 64'd0);

    // Instruction memory never ready: fault after 16 FETCH cycles.
    is_halt = 1'b0; imem_ready = 1'b0; run = 1'b1;
    tick();                                   // FETCH cycle 1
    for (int c = 2; c <= 16; c++) tick();
    chk("to_c16_fault", 64'(fault), 64'd0);
    chk("to_c16_req", 64'(imem_req), 64'd1);
    tick();
    chk("to_fault", 64'(fault), 64'd1);
    chk("to_fault_req", 64'(imem_req), 64'd0);
    imem_ready = 1'b1; tick(); tick();
    chk("to_fault_held", 64'(fault), 64'd1);
    do_reset();

    // Ready arrives exactly on cycle 16: proceeds normally.
    imem_ready = 1'b0; run = 1'b1;
    tick();
    for (int c = 2; c <= 16; c++) tick();
    imem_ready = 1'b1;
    settle();
    chk("race_ir_load", 64'(ir_load), 64'd1);
    tick();                                   // DECODE
    chk("race_no_fault", 64'(fault), 64'd0);
    tick();                                   // EXEC: branch retires
    run = 1'b0;
    settle();
    chk("race_pc", 64'(pc_enable), 64'd1);
    tick();
    chk("race_idle_strobes", 64'(strobes()), 64'h0);
    chk("race_retired", 64'(retired), 64'd1);

    // Reset during WB discards the instruction.
    writes_reg = 1'b1; run = 1'b1;
    snap = pulses;
    tick(); tick(); tick(); tick();           // WB
    rst = 1'b1;
    settle();
    chk("rstwb_pc", 64'(pc_enable), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rstwb_retired", 64'(retired), 64'd0);
    chk("rstwb_pulses", 64'(pulses - snap), 64'd0);
    chk("rstwb_strobes", 64'(strobes()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
